// File: rtl/exe.sv
// Execute stage: ALU, shifter, branch resolution and a multi-cycle restoring
// divider. Produces the combinational fast-forward result for dec1 and
// registers results, rd control and branch redirects toward the next stage.
module exe #(
    parameter int XLEN         = 32,
    parameter int DIV_CYCLES   = 32,
    parameter int NB_UNIT      = 4,
    parameter int NB_OPERATION = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [XLEN-1:0]         pc_q_i,
    input  logic                    rd_v_q_i,
    input  logic [4:0]              rd_adr_q_i,
    input  logic [XLEN:0]           rs1_data_qual_q_i,
    input  logic [XLEN:0]           rs2_data_qual_q_i,
    input  logic [XLEN-1:0]         branch_imm_q_i,
    input  logic                    unsign_ext_q_i,
    input  logic [NB_UNIT-1:0]      unit_q_i,
    input  logic [NB_OPERATION-1:0] operation_q_i,
    output logic [XLEN-1:0]         exe_ff_res_data_o,
    output logic                    stall_o,
    output logic                    branch_v_q_o,
    output logic [XLEN-1:0]         branch_target_q_o,
    output logic                    rd_v_q_o,
    output logic [4:0]              rd_adr_q_o,
    output logic [XLEN-1:0]         res_data_q_o
);

    // Operation encodings within each unit
    localparam logic [NB_OPERATION-1:0] ALU_ADD   = 4'd0;
    localparam logic [NB_OPERATION-1:0] ALU_SLT   = 4'd1;
    localparam logic [NB_OPERATION-1:0] ALU_SLTU  = 4'd2;
    localparam logic [NB_OPERATION-1:0] ALU_AND   = 4'd3;
    localparam logic [NB_OPERATION-1:0] ALU_OR    = 4'd4;
    localparam logic [NB_OPERATION-1:0] ALU_XOR   = 4'd5;
    localparam logic [NB_OPERATION-1:0] ALU_LUI   = 4'd6;
    localparam logic [NB_OPERATION-1:0] ALU_AUIPC = 4'd7;
    localparam logic [NB_OPERATION-1:0] SH_SLL    = 4'd0;
    localparam logic [NB_OPERATION-1:0] SH_SRL    = 4'd1;
    localparam logic [NB_OPERATION-1:0] SH_SRA    = 4'd2;
    localparam logic [NB_OPERATION-1:0] BR_BEQ    = 4'd0;
    localparam logic [NB_OPERATION-1:0] BR_BNE    = 4'd1;
    localparam logic [NB_OPERATION-1:0] BR_BLT    = 4'd2;
    localparam logic [NB_OPERATION-1:0] BR_BGE    = 4'd3;
    localparam logic [NB_OPERATION-1:0] BR_BLTU   = 4'd4;
    localparam logic [NB_OPERATION-1:0] BR_BGEU   = 4'd5;
    localparam logic [NB_OPERATION-1:0] BR_JAL    = 4'd6;
    localparam logic [NB_OPERATION-1:0] BR_JALR   = 4'd7;
    // Divider ops: bit 1 selects the remainder (DIV=0, DIVU=1, REM=2, REMU=3)

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam int SH_W  = $clog2(XLEN);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    div_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  count_reg;
    logic [XLEN-1:0]   quo_reg, rem_reg, dvs_reg;
    logic              q_neg_reg, r_neg_reg, rem_sel_reg;

    logic              killed, div_start, stall_raw, stall;
    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   alu_res, shift_res, res_comb, target_comb;
    logic              branch_cond, branch_taken;
    logic [SH_W-1:0]   shamt;
    logic signed [XLEN:0] sra_full;
    logic              s1, s2;
    logic [XLEN-1:0]   mag1, mag2, quo_fix, rem_fix, div_res;
    logic [XLEN:0]     r_shift;
    logic [XLEN+1:0]   diff;
    logic              ge;

    assign killed = branch_v_q_o;
    assign sum    = rs1_data_qual_q_i + rs2_data_qual_q_i;
    assign shamt  = rs2_data_qual_q_i[SH_W-1:0];
    assign sra_full = $signed(rs1_data_qual_q_i) >>> shamt;

    // ALU result selection
    always_comb begin
        alu_res = '0;
        case (operation_q_i)
            ALU_ADD, ALU_LUI, ALU_AUIPC: alu_res = sum[XLEN-1:0];
            ALU_SLT, ALU_SLTU:           alu_res = {{(XLEN-1){1'b0}}, sum[XLEN]};
            ALU_AND: alu_res = rs1_data_qual_q_i[XLEN-1:0] & rs2_data_qual_q_i[XLEN-1:0];
            ALU_OR:  alu_res = rs1_data_qual_q_i[XLEN-1:0] | rs2_data_qual_q_i[XLEN-1:0];
            ALU_XOR: alu_res = rs1_data_qual_q_i[XLEN-1:0] ^ rs2_data_qual_q_i[XLEN-1:0];
            default: alu_res = '0;
        endcase
    end

    // Shifter result selection; SRA fills with the 33rd (sign) bit
    always_comb begin
        shift_res = '0;
        case (operation_q_i)
            SH_SLL:  shift_res = rs1_data_qual_q_i[XLEN-1:0] << shamt;
            SH_SRL:  shift_res = rs1_data_qual_q_i[XLEN-1:0] >> shamt;
            SH_SRA:  shift_res = sra_full[XLEN-1:0];
            default: shift_res = '0;
        endcase
    end

    // Branch condition from the shared adder; jumps are unconditional
    always_comb begin
        branch_cond = 1'b0;
        case (operation_q_i)
            BR_BEQ:          branch_cond = (sum[XLEN-1:0] == '0);
            BR_BNE:          branch_cond = (sum[XLEN-1:0] != '0);
            BR_BLT, BR_BLTU: branch_cond = sum[XLEN];
            BR_BGE, BR_BGEU: branch_cond = ~sum[XLEN];
            BR_JAL, BR_JALR: branch_cond = 1'b1;
            default:         branch_cond = 1'b0;
        endcase
    end

    assign target_comb  = (operation_q_i == BR_JALR) ? {sum[XLEN-1:1], 1'b0}
                                                     : pc_q_i + branch_imm_q_i;
    assign branch_taken = unit_q_i[2] & branch_cond & ~killed & ~stall;

    // Divider operand magnitudes and one restoring step
    assign s1   = ~unsign_ext_q_i & rs1_data_qual_q_i[XLEN];
    assign s2   = ~unsign_ext_q_i & rs2_data_qual_q_i[XLEN];
    assign mag1 = s1 ? -rs1_data_qual_q_i[XLEN-1:0] : rs1_data_qual_q_i[XLEN-1:0];
    assign mag2 = s2 ? -rs2_data_qual_q_i[XLEN-1:0] : rs2_data_qual_q_i[XLEN-1:0];
    assign r_shift = {rem_reg, quo_reg[XLEN-1]};
    assign diff    = {1'b0, r_shift} - {2'b00, dvs_reg};
    assign ge      = ~diff[XLEN+1];
    assign quo_fix = q_neg_reg ? -quo_reg : quo_reg;
    assign rem_fix = r_neg_reg ? -rem_reg : rem_reg;
    assign div_res = rem_sel_reg ? rem_fix : quo_fix;

    assign div_start = unit_q_i[3] & ~killed & (state_reg == DIV_IDLE);

    // Divider next-state and stall generation
    always_comb begin
        state_next = state_reg;
        stall_raw  = 1'b0;
        case (state_reg)
            DIV_IDLE: if (div_start) begin
                stall_raw  = 1'b1;
                state_next = DIV_BUSY;
            end
            DIV_BUSY: begin
                stall_raw = 1'b1;
                if (count_reg == '0) state_next = DIV_DONE;
            end
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // Stall drops as soon as reset is applied, even with a DIV still presented
    assign stall   = stall_raw & reset_n;
    assign stall_o = stall;

    // Result mux feeding both the fast-forward path and the output flops
    always_comb begin
        res_comb = '0;
        if (state_reg == DIV_DONE) res_comb = div_res;
        else if (unit_q_i[0])      res_comb = alu_res;
        else if (unit_q_i[1])      res_comb = shift_res;
        else if (unit_q_i[2])      res_comb = pc_q_i + XLEN'(4);
    end
    assign exe_ff_res_data_o = res_comb;

    // Divider state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= DIV_IDLE;
        else          state_reg <= state_next;
    end

    // Divider datapath: operand capture on start, one step per busy cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg   <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            dvs_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            rem_sel_reg <= 1'b0;
        end else if (div_start) begin
            count_reg   <= CNT_W'(DIV_CYCLES - 1);
            quo_reg     <= mag1;
            rem_reg     <= '0;
            dvs_reg     <= mag2;
            // Divide by zero keeps the all-ones quotient unsigned-looking
            q_neg_reg   <= (s1 ^ s2) & (rs2_data_qual_q_i[XLEN-1:0] != '0);
            r_neg_reg   <= s1;
            rem_sel_reg <= operation_q_i[1];
        end else if (state_reg == DIV_BUSY) begin
            quo_reg <= {quo_reg[XLEN-2:0], ge};
            rem_reg <= ge ? diff[XLEN-1:0] : r_shift[XLEN-1:0];
            if (count_reg != '0) count_reg <= count_reg - 1'b1;
        end
    end

    // Output flops: bubble while stalled, only rd_v is qualified by the kill
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_v_q_o      <= 1'b0;
            branch_target_q_o <= '0;
            rd_v_q_o          <= 1'b0;
            rd_adr_q_o        <= '0;
            res_data_q_o      <= '0;
        end else begin
            branch_v_q_o <= branch_taken;
            if (stall) begin
                rd_v_q_o <= 1'b0;
            end else begin
                rd_v_q_o          <= rd_v_q_i & ~killed;
                rd_adr_q_o        <= rd_adr_q_i;
                res_data_q_o      <= res_comb;
                branch_target_q_o <= target_comb;
            end
        end
    end

endmodule

// File: tb/tb_exe.sv
// Scoreboard bench for the execute stage: stimulus pushes expected retirements,
// a monitor pops them whenever rd_v_q_o is seen; branch/stall/reset checked inline.
module tb_exe;

    localparam logic [3:0] U_ALU = 4'b0001, U_SH = 4'b0010, U_BR = 4'b0100, U_DIV = 4'b1000;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SLT = 4'd1, ALU_AND = 4'd3, ALU_OR = 4'd4, ALU_XOR = 4'd5;
    localparam logic [3:0] SH_SLL = 4'd0, SH_SRL = 4'd1, SH_SRA = 4'd2;
    localparam logic [3:0] BR_BEQ = 4'd0, BR_BNE = 4'd1, BR_JAL = 4'd6, BR_JALR = 4'd7;
    localparam logic [3:0] D_DIV = 4'd0, D_DIVU = 4'd1, D_REM = 4'd2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc, imm;
    logic        rd_v;
    logic [4:0]  rd_adr;
    logic [32:0] rs1, rs2;
    logic        uns;
    logic [3:0]  unit, op;
    logic [31:0] ff_res, br_target, res_q;
    logic        stall, br_v, rd_v_q;
    logic [4:0]  rd_adr_q;

    always #5 clk = ~clk;

    exe dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pc_q_i            (pc),
        .rd_v_q_i          (rd_v),
        .rd_adr_q_i        (rd_adr),
        .rs1_data_qual_q_i (rs1),
        .rs2_data_qual_q_i (rs2),
        .branch_imm_q_i    (imm),
        .unsign_ext_q_i    (uns),
        .unit_q_i          (unit),
        .operation_q_i     (op),
        .exe_ff_res_data_o (ff_res),
        .stall_o           (stall),
        .branch_v_q_o      (br_v),
        .branch_target_q_o (br_target),
        .rd_v_q_o          (rd_v_q),
        .rd_adr_q_o        (rd_adr_q),
        .res_data_q_o      (res_q)
    );

    typedef struct packed {logic [4:0] adr; logic [31:0] data;} exp_t;
    exp_t exp_q[$];
    exp_t exp_e;
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    endtask

    // Monitor: every registered write must match the oldest expected one
    always @(negedge clk) begin
        if (reset_n && rd_v_q) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_retire: got rd=%0d data=0x%08h required none", rd_adr_q, res_q);
            end else begin
                exp_e = exp_q.pop_front();
                $display("retire rd=%0d data=0x%08h (expect rd=%0d data=0x%08h)", rd_adr_q, res_q, exp_e.adr, exp_e.data);
                check("retire_adr", {27'b0, rd_adr_q}, {27'b0, exp_e.adr});
                check("retire_data", res_q, exp_e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] u, input logic [3:0] o, input logic un,
                         input logic [32:0] a, input logic [32:0] b,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic w, input logic [4:0] rd);
        unit = u; op = o; uns = un; rs1 = a; rs2 = b; pc = p; imm = im; rd_v = w; rd_adr = rd;
    endtask

    task automatic bubble();
        drive(4'd0, 4'd0, 1'b0, 33'd0, 33'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Single-cycle op: check the fast-forward value, queue the retirement
    task automatic alu(input string name, input logic [3:0] u, input logic [3:0] o,
                       input logic [32:0] a, input logic [32:0] b,
                       input logic [4:0] rd, input logic [31:0] req);
        drive(u, o, 1'b0, a, b, 32'd0, 32'd0, 1'b1, rd);
        exp_q.push_back({rd, req});
        @(negedge clk);
        $display("issue %s rs1=0x%09h rs2=0x%09h ff=0x%08h", name, a, b, ff_res);
        check({name, "_ff"}, ff_res, req);
        step();
    endtask

    task automatic run_div(input string name, input logic [3:0] o, input logic un,
                           input logic [32:0] a, input logic [32:0] b,
                           input logic [4:0] rd, input logic [31:0] req);
        int n;
        n = 0;
        drive(U_DIV, o, un, a, b, 32'd0, 32'd0, 1'b1, rd);
        exp_q.push_back({rd, req});
        forever begin
            @(negedge clk);
            if (!stall || n > 200) break;
            n++;
        end
        $display("issue %s rs1=0x%09h rs2=0x%09h stall_cycles=%0d", name, a, b, n);
        check({name, "_stall_cycles"}, n, 33);
        step();
        bubble();
        @(negedge clk);
        step();
    endtask

    initial begin
        bubble();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd_v", rd_v_q, 0);
        check("reset_branch_v", br_v, 0);
        check("reset_target", br_target, 0);
        check("reset_res", res_q, 0);
        check("reset_stall", stall, 0);
        step();
        reset_n = 1'b1;
        step();

        alu("add",  U_ALU, ALU_ADD, 33'h0_00000005, 33'h1_FFFFFFFD, 5'd7,  32'h00000002);
        alu("slt",  U_ALU, ALU_SLT, 33'h0_00000003, 33'h1_FFFFFFFB, 5'd8,  32'h00000001);
        alu("and",  U_ALU, ALU_AND, 33'h0_F0F0F0F0, 33'h0_FF00FF00, 5'd9,  32'hF000F000);
        alu("or",   U_ALU, ALU_OR,  33'h0_F0F0F0F0, 33'h0_FF00FF00, 5'd10, 32'hFFF0FFF0);
        alu("xor",  U_ALU, ALU_XOR, 33'h0_F0F0F0F0, 33'h0_FF00FF00, 5'd11, 32'h0FF00FF0);
        alu("sra",  U_SH,  SH_SRA,  33'h1_80000000, 33'h0_00000004, 5'd12, 32'hF8000000);
        alu("srl",  U_SH,  SH_SRL,  33'h0_80000000, 33'h0_00000004, 5'd13, 32'h08000000);
        alu("sll",  U_SH,  SH_SLL,  33'h0_00000001, 33'h0_0000001F, 5'd14, 32'h80000000);

        // BEQ taken, then a wrong-path JAL that must neither write nor branch
        drive(U_BR, BR_BEQ, 1'b0, 33'h0_00000005, 33'h1_FFFFFFFB, 32'h100, 32'h20, 1'b0, 5'd0);
        step();
        drive(U_BR, BR_JAL, 1'b0, 33'd0, 33'd0, 32'h500, 32'h40, 1'b1, 5'd15);
        @(negedge clk);
        $display("issue beq pc=0x100 branch_v=%0d target=0x%08h", br_v, br_target);
        check("beq_taken", br_v, 1);
        check("beq_target", br_target, 32'h120);
        step();
        bubble();
        @(negedge clk);
        check("killed_no_branch", br_v, 0);
        check("killed_no_write", rd_v_q, 0);
        step();

        // BNE with equal operands is not taken
        drive(U_BR, BR_BNE, 1'b0, 33'h0_00000005, 33'h1_FFFFFFFB, 32'h400, 32'h20, 1'b0, 5'd0);
        step();
        bubble();
        @(negedge clk);
        $display("issue bne pc=0x400 branch_v=%0d", br_v);
        check("bne_not_taken", br_v, 0);
        step();

        // JAL writes pc+4 and redirects
        drive(U_BR, BR_JAL, 1'b0, 33'd0, 33'd0, 32'h200, 32'h40, 1'b1, 5'd1);
        exp_q.push_back({5'd1, 32'h204});
        step();
        bubble();
        @(negedge clk);
        $display("issue jal pc=0x200 branch_v=%0d target=0x%08h", br_v, br_target);
        check("jal_taken", br_v, 1);
        check("jal_target", br_target, 32'h240);
        step();

        // JALR target = (rs1 + imm) with bit 0 cleared
        drive(U_BR, BR_JALR, 1'b0, 33'h0_00001001, 33'h0_00000010, 32'h300, 32'h0, 1'b1, 5'd2);
        exp_q.push_back({5'd2, 32'h304});
        step();
        bubble();
        @(negedge clk);
        $display("issue jalr pc=0x300 branch_v=%0d target=0x%08h", br_v, br_target);
        check("jalr_taken", br_v, 1);
        check("jalr_target", br_target, 32'h1010);
        step();

        run_div("div_neg7_2",  D_DIV,  1'b0, 33'h1_FFFFFFF9, 33'h0_00000002, 5'd20, 32'hFFFFFFFD);
        run_div("rem_neg7_2",  D_REM,  1'b0, 33'h1_FFFFFFF9, 33'h0_00000002, 5'd21, 32'hFFFFFFFF);
        run_div("div_9_0",     D_DIV,  1'b0, 33'h0_00000009, 33'h0_00000000, 5'd22, 32'hFFFFFFFF);
        run_div("rem_9_0",     D_REM,  1'b0, 33'h0_00000009, 33'h0_00000000, 5'd23, 32'h00000009);
        run_div("div_ovf",     D_DIV,  1'b0, 33'h1_80000000, 33'h1_FFFFFFFF, 5'd24, 32'h80000000);
        run_div("divu_100_7",  D_DIVU, 1'b1, 33'h0_00000064, 33'h0_00000007, 5'd25, 32'h0000000E);

        // Reset in the middle of a division
        alu("pre_add", U_ALU, ALU_ADD, 33'h0_00000050, 33'h0_00000005, 5'd5, 32'h00000055);
        drive(U_DIV, D_DIV, 1'b0, 33'h0_00000064, 33'h0_00000003, 32'h0, 32'h0, 1'b1, 5'd26);
        repeat (11) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        $display("reset mid-division stall=%0d res=0x%08h", stall, res_q);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_rd_v", rd_v_q, 0);
        check("rst_mid_res", res_q, 0);
        check("rst_mid_adr", {27'b0, rd_adr_q}, 0);
        bubble();
        step();
        reset_n = 1'b1;
        step();
        drive(U_ALU, ALU_ADD, 1'b0, 33'h0_00000010, 33'h0_00000020, 32'h0, 32'h0, 1'b1, 5'd3);
        @(negedge clk);
        check("post_rst_no_stall", stall, 0);
        step();
        bubble();
        exp_q.push_back({5'd3, 32'h30});
        @(negedge clk);
        check("post_rst_rd_v", rd_v_q, 1);
        repeat (3) step();

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
